// File: rtl/fetch_unit_if.sv
// Fetch-unit bus: control/operand inputs from the execute stage and the
// registered instruction-memory address, write enable and PC going back out.
interface fetch_unit_if;
    logic        fetch_start;
    logic [3:0]  opCode_in;
    logic [8:0]  offset_in;
    logic [15:0] reg_in;
    logic [2:0]  br_nzp;
    logic [2:0]  result_nzp;
    logic [15:0] addr_out;
    logic        wea_out;
    logic [15:0] pc;

    modport master (
        output fetch_start, opCode_in, offset_in, reg_in, br_nzp, result_nzp,
        input  addr_out, wea_out, pc
    );

    modport slave (
        input  fetch_start, opCode_in, offset_in, reg_in, br_nzp, result_nzp,
        output addr_out, wea_out, pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, BR/JMP next-PC selection and memory address.
// Define FETCH_JSRR_EN to make opcode 0100 (JSRR) redirect the PC to reg_in.
module fetch_unit (
    input  logic          clk,
    input  logic          rst_n,
    fetch_unit_if.slave   bus
);

    typedef enum logic {
        S_FIRST,
        S_RUN
    } state_t;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_JMP  = 4'b1100;
`ifdef FETCH_JSRR_EN
    localparam logic [3:0] OP_JSRR = 4'b0100;
`endif

    state_t      state, state_nx;
    logic [15:0] pc_q, pc_nx;
    logic [15:0] addr_q, addr_nx;
    logic [15:0] pc_inc;
    logic [15:0] offset_sext;
    logic [15:0] next_pc;
    logic        br_taken;

    assign pc_inc      = pc_q + 16'd1;
    assign offset_sext = {{7{bus.offset_in[8]}}, bus.offset_in};
    assign br_taken    = |(bus.br_nzp & bus.result_nzp);

    // 16-bit adds wrap naturally, so 0xFFFF + 1 lands on 0x0000.
    always_comb begin
        next_pc = pc_inc;
        case (bus.opCode_in)
            OP_BR:   next_pc = br_taken ? (pc_inc + offset_sext) : pc_inc;
            OP_JMP:  next_pc = bus.reg_in;
`ifdef FETCH_JSRR_EN
            OP_JSRR: next_pc = bus.reg_in;
`endif
            default: next_pc = pc_inc;
        endcase
    end

    // NOTE: every output of this block gets a hold value first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nx = state;
        pc_nx    = pc_q;
        addr_nx  = addr_q;
        if (bus.fetch_start) begin
            case (state)
                S_FIRST: begin
                    // The very first fetch reads the reset PC without advancing it.
                    addr_nx  = pc_q;
                    state_nx = S_RUN;
                end
                S_RUN: begin
                    pc_nx   = next_pc;
                    addr_nx = next_pc;
                end
                default: state_nx = S_FIRST;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state  <= S_FIRST;
            pc_q   <= 16'h0000;
            addr_q <= 16'h0000;
        end else begin
            state  <= state_nx;
            pc_q   <= pc_nx;
            addr_q <= addr_nx;
        end
    end

    assign bus.pc       = pc_q;
    assign bus.addr_out = addr_q;
    assign bus.wea_out  = 1'b0;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// compared against a behavioural PC model.
module tb_fetch_unit;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    fetch_unit_if bus ();

    fetch_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state
    int m_pc;
    int m_addr;
    bit m_first;

    function automatic int ref_next(int p, int op, int off, int rg, int br, int res);
        int soff;
        int t;
        soff = (off >= 256) ? off - 512 : off;
        if (op == 0 && (br & res) != 0) t = p + 1 + soff;
        else if (op == 12)              t = rg;
`ifdef FETCH_JSRR_EN
        else if (op == 4)               t = rg;
`endif
        else                            t = p + 1;
        return ((t % 65536) + 65536) % 65536;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"},   bus.pc,               16'(m_pc));
        check({tag, ".addr"}, bus.addr_out,         16'(m_addr));
        check({tag, ".wea"},  {15'd0, bus.wea_out}, 16'd0);
    endtask

    // Apply one cycle of inputs, advance the model on the edge, check #1 later.
    task automatic cycle(input string tag, input bit fs, input int op, input int off,
                         input int rg, input int br, input int res);
        bus.fetch_start = fs;
        bus.opCode_in   = 4'(op);
        bus.offset_in   = 9'(off);
        bus.reg_in      = 16'(rg);
        bus.br_nzp      = 3'(br);
        bus.result_nzp  = 3'(res);
        @(posedge clk);
        if (fs) begin
            if (m_first) begin
                m_addr  = m_pc;
                m_first = 1'b0;
            end else begin
                m_pc   = ref_next(m_pc, op, off, rg, br, res);
                m_addr = m_pc;
            end
        end
        #1;
        check_all(tag);
    endtask

    task automatic model_reset();
        m_pc    = 0;
        m_addr  = 0;
        m_first = 1'b1;
    endtask

    // Redirect the PC to a known value with a JMP pulse.
    task automatic jump_to(input int target);
        cycle("jmp", 1'b1, 12, 0, target, 0, 0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        bus.fetch_start = 1'b0;
        bus.opCode_in   = 4'd0;
        bus.offset_in   = 9'd0;
        bus.reg_in      = 16'd0;
        bus.br_nzp      = 3'd0;
        bus.result_nzp  = 3'd0;

        // Reset for 5 cycles, outputs must be zero immediately
        rst_n = 1'b1;
        model_reset();
        #1;
        check_all("rst_async");
        repeat (5) @(posedge clk);
        #1;
        check_all("rst_hold");
        rst_n = 1'b0;

        // Idle after release with JMP on the bus: nothing moves
        for (int i = 0; i < 4; i++) cycle("idle", 1'b0, 12, 0, 16'h1234, 7, 7);

        // Three fetch pulses: 0x0000, 0x0001, 0x0002
        for (int i = 0; i < 3; i++) begin
            cycle("seq", 1'b1, 1, 0, 0, 0, 0);
            check("seq_val", bus.pc, 16'(i));
            cycle("seq_gap", 1'b0, 1, 0, 0, 0, 0);
        end

        // Advance to 0x0005, then JMP to 0x3000
        for (int i = 0; i < 3; i++) cycle("adv", 1'b1, 1, 0, 0, 0, 0);
        check("pc_at_5", bus.pc, 16'h0005);
        cycle("jmp3000", 1'b1, 12, 0, 16'h3000, 0, 0);
        check("jmp3000_val", bus.addr_out, 16'h3000);

        // Branch taken backwards by 2, then not taken
        jump_to(16'h0010);
        cycle("br_taken", 1'b1, 0, 9'h1FE, 0, 3'b010, 3'b010);
        check("br_taken_val", bus.pc, 16'h000F);
        jump_to(16'h0010);
        cycle("br_not", 1'b1, 0, 9'h1FE, 0, 3'b010, 3'b100);
        check("br_not_val", bus.pc, 16'h0011);

        // Mask 000 never branches, 111 always does
        cycle("br_000", 1'b1, 0, 9'h020, 0, 3'b000, 3'b111);
        check("br_000_val", bus.pc, 16'h0012);
        cycle("br_111", 1'b1, 0, 9'h020, 0, 3'b111, 3'b001);
        check("br_111_val", bus.pc, 16'h0033);

        // JSRR opcode: redirect only when the option is compiled in
        cycle("jsrr", 1'b1, 4, 0, 16'hABCD, 0, 0);

        // fetch_start low ignores a JMP
        cycle("hold", 1'b0, 12, 0, 16'h7777, 0, 0);

        // Wrap from 0xFFFF to 0x0000
        jump_to(16'hFFFF);
        cycle("wrap", 1'b1, 1, 0, 0, 0, 0);
        check("wrap_val", bus.pc, 16'h0000);

        // Randomized run with a mid-cycle asynchronous reset partway through
        for (int i = 0; i < 400; i++) begin
            int op_sel;
            int op;
            op_sel = int'($urandom_range(0, 9));
            op = (op_sel < 4) ? 0 : (op_sel < 6) ? 12 : (op_sel == 6) ? 4 : int'($urandom_range(0, 15));
            cycle("rand", 1'($urandom_range(0, 3) != 0), op, int'($urandom_range(0, 511)),
                  int'($urandom_range(0, 65535)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)));
            if (i == 200) begin
                #3;
                rst_n = 1'b1;
                model_reset();
                #1;
                check_all("mid_rst");
                @(posedge clk);
                #1;
                rst_n = 1'b0;
                check_all("mid_rst_rel");
                // First fetch after release must not advance the PC
                cycle("post_rst_first", 1'b1, 12, 0, 16'h4444, 0, 0);
                check("post_rst_pc", bus.pc, 16'h0000);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-high (asserted = 1).
REQ-003 fetch_start  input  1  one-cycle request to advance PC and issue an instruction read.
REQ-004 opCode_in  input  4  opcode of the most recently executed instruction.
REQ-005 offset_in  input  9  PCoffset9 field of that instruction, two's complement.
REQ-006 reg_in  input  16  base-register value (JMP/JSRR target).
REQ-007 br_nzp  input  3  BR condition mask, bit2=n, bit1=z, bit0=p.
REQ-008 result_nzp  input  3  current condition codes, same bit order.
REQ-009 addr_out  output  16  instruction-memory address, registered.
REQ-010 wea_out  output  1  memory write enable, registered.
REQ-011 pc  output  16  current program counter, registered.

Function
REQ-012 The unit SHALL hold a 16-bit PC register and a 1-bit first-fetch flag, set by reset.
REQ-013 The unit SHALL compute next_pc combinationally: BR (0000) taken when (br_nzp & result_nzp) != 0 -> pc + 1 + sext(offset_in); BR not taken -> pc + 1; JMP (1100) -> reg_in; all other opcodes -> pc + 1.
REQ-014 All PC arithmetic SHALL be modulo 2^16 (0xFFFF + 1 wraps to 0x0000, no flag).
REQ-015 On a rising edge with fetch_start=1 and first-fetch flag set, pc SHALL stay unchanged, addr_out SHALL load pc, and the flag SHALL clear.
REQ-016 On a rising edge with fetch_start=1 and flag clear, pc and addr_out SHALL both load next_pc (single-cycle latency).
REQ-017 On a rising edge with fetch_start=0, pc, addr_out and the flag SHALL hold; opCode_in and other inputs SHALL be ignored.
REQ-018 wea_out SHALL be 0 at all times (fetch only reads memory).
REQ-019 br_nzp = 000 SHALL never take a branch; 111 SHALL always take it.
REQ-020 fetch_start held high for N cycles SHALL perform N successive updates.

Reset
REQ-021 While rst_n=1, pc, addr_out, wea_out SHALL be 0x0000/0 immediately (asynchronous), and the first-fetch flag SHALL be 1.
REQ-022 Reset asserted mid-sequence SHALL abort it; the first fetch_start after release behaves per REQ-015.
REQ-023 After release with fetch_start=0, all outputs SHALL remain 0 indefinitely.

Configuration
REQ-024 Macro FETCH_JSRR_EN: when defined, opcode 0100 SHALL set next_pc = reg_in (JSRR redirect); when undefined, opcode 0100 SHALL give next_pc = pc + 1.

Verification
REQ-025 Reset 5 cycles, release, opCode_in=1100, fetch_start=0 -> addr_out=0x0000, wea_out=0, pc=0x0000.
REQ-026 After reset, three fetch_start pulses, opCode_in=0001 -> pc/addr_out sequence 0x0000, 0x0001, 0x0002; wea_out=0.
REQ-027 pc=0x0010, opCode_in=0000, br_nzp=010, result_nzp=010, offset_in=0x1FE (-2) -> pc=addr_out=0x000F; with result_nzp=100 -> 0x0011.
REQ-028 pc=0x0005, opCode_in=1100, reg_in=0x3000, fetch_start pulse -> pc=addr_out=0x3000.
REQ-029 pc=0xFFFF, opCode_in=0001, fetch_start -> pc=0x0000; reset asserted mid-run -> outputs 0 before next clock edge.
